// File: rtl/pixel_scheduler_pkg.sv
// Shared types for the ray pipeline: fixed-point scalars, vectors and the pixel
// scheduler state encoding.
package pixel_scheduler_pkg;

    localparam int unsigned FP_WIDTH     = 32;
    localparam int unsigned FP_FRAC_BITS = 24;
    localparam int unsigned COORD_W      = 7;
    localparam int unsigned TAG_W        = 16;
    localparam int unsigned CREDIT_W     = 8;

    typedef logic signed [FP_WIDTH-1:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Integer screen coordinate to Q8.24
    function automatic fp coord_to_fp(input logic [COORD_W-1:0] v);
        return fp'({{(FP_WIDTH-FP_FRAC_BITS-COORD_W){1'b0}}, v, {FP_FRAC_BITS{1'b0}}});
    endfunction

endpackage

// File: rtl/credit_counter.sv
// In-flight credit tracker: counts issued-minus-retired work items up to MAX,
// flags a sticky underflow when a retire arrives with nothing outstanding.
module credit_counter
    import pixel_scheduler_pkg::*;
#(
    parameter int unsigned MAX = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_err_i,
    input  logic                issue_i,
    input  logic                retire_i,
    output logic [CREDIT_W-1:0] count_o,
    output logic                full_o,
    output logic                underflow_err_o
);

    logic [CREDIT_W-1:0] count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    // Issue and retire in the same cycle cancel out
    always_comb begin
        count_d = count_q;
        err_d   = err_q & ~clr_err_i;
        if (issue_i && !retire_i) begin
            count_d = count_q + 1'b1;
        end else if (!issue_i && retire_i) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
        full_d = (count_d == CREDIT_W'(MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign count_o         = count_q;
    assign full_o          = full_q;
    assign underflow_err_o = err_q;

endmodule

// File: rtl/pixel_scheduler.sv
// Raster-scan pixel issuer for ray_generator with credit-based throttling.
// Optional PIXEL_SCHED_PERF_EN adds the stall_cycles performance counter.
module pixel_scheduler
    import pixel_scheduler_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 128,
    parameter int unsigned SCREEN_HEIGHT = 128,
    parameter int unsigned MAX_INFLIGHT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                ray_retire,
    output fp                   screen_x,
    output fp                   screen_y,
    output logic                valid_out,
    output logic [TAG_W-1:0]    pixel_tag,
    output logic                busy,
    output logic                frame_done,
    output logic [CREDIT_W-1:0] inflight,
    output logic                retire_err
`ifdef PIXEL_SCHED_PERF_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(SCREEN_HEIGHT - 1);

    sched_state_t        state_q, state_d;
    logic [COORD_W-1:0]  col_q, col_d, row_q, row_d;
    logic [TAG_W-1:0]    tag_cnt_q, tag_cnt_d;
    logic                aborted_q, aborted_d;
    fp                   sx_q, sx_d, sy_q, sy_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic                start_ok_c, issue_c, is_last_c;
    logic [COORD_W-1:0]  cur_col_c, cur_row_c;
    logic [TAG_W-1:0]    cur_tag_c;
    logic [CREDIT_W-1:0] credit_count;
    logic                credit_full;

    credit_counter #(
        .MAX (MAX_INFLIGHT)
    ) u_credit (
        .clk             (clk),
        .rst_n           (rst),
        .clr_err_i       (start_ok_c),
        .issue_i         (issue_c),
        .retire_i        (ray_retire),
        .count_o         (credit_count),
        .full_o          (credit_full),
        .underflow_err_o (retire_err)
    );

    // A start issues pixel (0,0) in the same cycle so valid_out follows start directly
    always_comb begin
        start_ok_c = start && !abort && (state_q == IDLE || state_q == DONE);
        issue_c    = (start_ok_c || (state_q == RUN && !abort)) && !credit_full;
        cur_col_c  = start_ok_c ? '0 : col_q;
        cur_row_c  = start_ok_c ? '0 : row_q;
        cur_tag_c  = start_ok_c ? '0 : tag_cnt_q;
        is_last_c  = (cur_col_c == LAST_COL) && (cur_row_c == LAST_ROW);
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        tag_cnt_d    = tag_cnt_q;
        aborted_d    = aborted_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        tag_d        = tag_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;

        if (start_ok_c) begin
            state_d   = RUN;
            col_d     = '0;
            row_d     = '0;
            tag_cnt_d = '0;
            aborted_d = 1'b0;
        end

        if (issue_c) begin
            sx_d      = coord_to_fp(cur_col_c);
            sy_d      = coord_to_fp(cur_row_c);
            tag_d     = cur_tag_c;
            valid_d   = 1'b1;
            tag_cnt_d = cur_tag_c + 16'd1;
            if (cur_col_c == LAST_COL) begin
                col_d = '0;
                row_d = cur_row_c + 7'd1;
            end else begin
                col_d = cur_col_c + 7'd1;
            end
            if (is_last_c) begin
                state_d = DRAIN;
            end
        end

        case (state_q)
            RUN: begin
                if (abort) begin
                    state_d   = DRAIN;
                    aborted_d = 1'b1;
                end
            end
            DRAIN: begin
                if (credit_count == '0) begin
                    state_d      = aborted_q ? IDLE : DONE;
                    frame_done_d = !aborted_q;
                end
            end
            default: ;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            tag_cnt_q    <= '0;
            aborted_q    <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            tag_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            tag_cnt_q    <= tag_cnt_d;
            aborted_q    <= aborted_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign screen_x   = sx_q;
    assign screen_y   = sy_q;
    assign pixel_tag  = tag_q;
    assign valid_out  = valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign inflight   = credit_count;

`ifdef PIXEL_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Counts RUN cycles lost to exhausted credits; saturating
    always_comb begin
        stall_d = stall_q;
        if (start_ok_c) begin
            stall_d = '0;
        end else if (state_q == RUN && !abort && credit_full && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: three instances (4x2/16 credits, 4x2/2 credits,
// 128x128/16 credits) sharing clock and reset.
module tb_pixel_scheduler;
    import pixel_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start [3];
    logic abort [3];
    logic retire [3];
    fp    sx [3];
    fp    sy [3];
    logic valid [3];
    logic [15:0] tag [3];
    logic busy [3];
    logic fdone [3];
    logic [7:0] infl [3];
    logic rerr [3];
`ifdef PIXEL_SCHED_PERF_EN
    logic [31:0] stall [3];
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] pipe_a = '0;
    logic auto_a = 1'b0;
    logic auto_c = 1'b0;

    always #5 clk = ~clk;

    pixel_scheduler #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .MAX_INFLIGHT(16)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .ray_retire(retire[0]),
        .screen_x(sx[0]), .screen_y(sy[0]), .valid_out(valid[0]), .pixel_tag(tag[0]),
        .busy(busy[0]), .frame_done(fdone[0]), .inflight(infl[0]), .retire_err(rerr[0])
`ifdef PIXEL_SCHED_PERF_EN
        , .stall_cycles(stall[0])
`endif
    );

    pixel_scheduler #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .ray_retire(retire[1]),
        .screen_x(sx[1]), .screen_y(sy[1]), .valid_out(valid[1]), .pixel_tag(tag[1]),
        .busy(busy[1]), .frame_done(fdone[1]), .inflight(infl[1]), .retire_err(rerr[1])
`ifdef PIXEL_SCHED_PERF_EN
        , .stall_cycles(stall[1])
`endif
    );

    pixel_scheduler #(.SCREEN_WIDTH(128), .SCREEN_HEIGHT(128), .MAX_INFLIGHT(16)) dut_c (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .ray_retire(retire[2]),
        .screen_x(sx[2]), .screen_y(sy[2]), .valid_out(valid[2]), .pixel_tag(tag[2]),
        .busy(busy[2]), .frame_done(fdone[2]), .inflight(infl[2]), .retire_err(rerr[2])
`ifdef PIXEL_SCHED_PERF_EN
        , .stall_cycles(stall[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, then update auto-retire drivers
    task automatic tick();
        @(posedge clk);
        #1;
        pipe_a = {pipe_a[1:0], valid[0]};
        if (auto_a) retire[0] = pipe_a[2];
        if (auto_c) retire[2] = valid[2];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_cnt;
        int fd_at;
        logic seen_v;
        logic seen_fd;
        int n_iss;
        int tag_err;
        logic [15:0] last_tag;
        fp last_x;
        fp last_y;

        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; retire[i] = 1'b0;
        end
        rst = 1'b0;
        #12;
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_tag", 32'(tag[0]), 32'd0);
        check("rst_inflight", 32'(infl[0]), 32'd0);
        check("rst_retire_err", 32'(rerr[0]), 32'd0);
        rst = 1'b1;
        tick();

        // 4x2 frame, retire three cycles after each issue
        auto_a = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("a_busy_run", 32'(busy[0]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check("a_valid", 32'(valid[0]), 32'd1);
            check("a_tag", 32'(tag[0]), 32'(k));
            check("a_x", sx[0], 32'(k % 4) << 24);
            check("a_y", sy[0], 32'(k / 4) << 24);
            if (k == 2) check("a_inflight3", 32'(infl[0]), 32'd3);
            if (k == 3) check("a_inflight_hold", 32'(infl[0]), 32'd3);
        end
        fd_cnt = 0; fd_at = 0; seen_v = 1'b0;
        for (int t = 9; t <= 15; t++) begin
            tick();
            seen_v |= valid[0];
            if (fdone[0]) begin fd_cnt++; fd_at = t; end
        end
        auto_a = 1'b0;
        retire[0] = 1'b0;
        check("a_no_extra_valid", 32'(seen_v), 32'd0);
        check("a_frame_done_count", 32'(fd_cnt), 32'd1);
        check("a_frame_done_cycle", 32'(fd_at), 32'd12);
        check("a_busy_done", 32'(busy[0]), 32'd0);
        check("a_inflight_done", 32'(infl[0]), 32'd0);
        check("a_retire_err", 32'(rerr[0]), 32'd0);

        // Abort after tag 3 with two rays in flight
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        retire[0] = 1'b1;
        tick();
        tick();
        check("ab_tag3", 32'(tag[0]), 32'd3);
        check("ab_inflight2", 32'(infl[0]), 32'd2);
        retire[0] = 1'b0;
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("ab_suppressed", 32'(valid[0]), 32'd0);
        check("ab_busy_drain", 32'(busy[0]), 32'd1);
        seen_v = 1'b0; seen_fd = 1'b0;
        for (int t = 0; t < 5; t++) begin
            retire[0] = (t == 2 || t == 3);
            tick();
            seen_v |= valid[0];
            seen_fd |= fdone[0];
        end
        retire[0] = 1'b0;
        check("ab_no_valid", 32'(seen_v), 32'd0);
        check("ab_no_frame_done", 32'(seen_fd), 32'd0);
        check("ab_busy_idle", 32'(busy[0]), 32'd0);
        check("ab_inflight0", 32'(infl[0]), 32'd0);

        // Retire with nothing in flight, then simultaneous issue and retire
        retire[0] = 1'b1;
        tick();
        retire[0] = 1'b0;
        check("ue_set", 32'(rerr[0]), 32'd1);
        check("ue_inflight", 32'(infl[0]), 32'd0);
        tick();
        tick();
        check("ue_sticky", 32'(rerr[0]), 32'd1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("ue_cleared", 32'(rerr[0]), 32'd0);
        check("sim_inflight1", 32'(infl[0]), 32'd1);
        retire[0] = 1'b1;
        tick();
        retire[0] = 1'b0;
        check("sim_valid", 32'(valid[0]), 32'd1);
        check("sim_tag", 32'(tag[0]), 32'd1);
        check("sim_inflight_hold", 32'(infl[0]), 32'd1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        retire[0] = 1'b1;
        tick();
        retire[0] = 1'b0;
        tick();
        check("sim_busy_idle", 32'(busy[0]), 32'd0);
        check("sim_no_err", 32'(rerr[0]), 32'd0);

        // Credit limit of two, no retires
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check("cr_tag0", 32'(tag[1]), 32'd0);
        check("cr_inflight1", 32'(infl[1]), 32'd1);
        tick();
        check("cr_tag1", 32'(tag[1]), 32'd1);
        check("cr_inflight2", 32'(infl[1]), 32'd2);
        seen_v = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            seen_v |= valid[1];
        end
        check("cr_blocked", 32'(seen_v), 32'd0);
        check("cr_inflight_full", 32'(infl[1]), 32'd2);
        retire[1] = 1'b1;
        tick();
        retire[1] = 1'b0;
        check("cr_retire_no_issue", 32'(valid[1]), 32'd0);
        check("cr_inflight_after_retire", 32'(infl[1]), 32'd1);
        tick();
        check("cr_reissue_valid", 32'(valid[1]), 32'd1);
        check("cr_reissue_tag", 32'(tag[1]), 32'd2);
        check("cr_reissue_x", sx[1], 32'h0200_0000);
        seen_v = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            seen_v |= valid[1];
        end
        check("cr_single_reissue", 32'(seen_v), 32'd0);
`ifdef PIXEL_SCHED_PERF_EN
        check("cr_stall_cycles", stall[1], 32'd7);
`endif

        // Full 128x128 frame with retire one cycle after each issue
        auto_c = 1'b1;
        start[2] = 1'b1;
        n_iss = 0; tag_err = 0; fd_cnt = 0;
        last_tag = '0; last_x = '0; last_y = '0;
        tick();
        start[2] = 1'b0;
        for (int t = 0; t < 16400; t++) begin
            if (t > 0) tick();
            if (valid[2]) begin
                if (tag[2] != 16'(n_iss)) tag_err++;
                n_iss++;
                last_tag = tag[2];
                last_x = sx[2];
                last_y = sy[2];
            end
            if (fdone[2]) fd_cnt++;
            if (t == 16383) check("big_throughput", 32'(n_iss), 32'd16384);
        end
        auto_c = 1'b0;
        retire[2] = 1'b0;
        check("big_issue_count", 32'(n_iss), 32'd16384);
        check("big_tag_seq", 32'(tag_err), 32'd0);
        check("big_last_tag", 32'(last_tag), 32'd16383);
        check("big_last_x", last_x, 32'h7F00_0000);
        check("big_last_y", last_y, 32'h7F00_0000);
        check("big_frame_done", 32'(fd_cnt), 32'd1);
        check("big_busy", 32'(busy[2]), 32'd0);
        check("big_retire_err", 32'(rerr[2]), 32'd0);
`ifdef PIXEL_SCHED_PERF_EN
        check("big_stall_cycles", stall[2], 32'd0);
`endif

        // Asynchronous reset in the middle of a frame
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        check("mr_tag5", 32'(tag[0]), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check("mr_valid", 32'(valid[0]), 32'd0);
        check("mr_busy", 32'(busy[0]), 32'd0);
        check("mr_tag", 32'(tag[0]), 32'd0);
        check("mr_x", sx[0], 32'd0);
        check("mr_y", sy[0], 32'd0);
        check("mr_inflight", 32'(infl[0]), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        check("mr_idle_valid", 32'(valid[0]), 32'd0);
        check("mr_idle_busy", 32'(busy[0]), 32'd0);
        tick();
        check("mr_idle_valid2", 32'(valid[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
